memory_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory bus between the instruction-fetch requester (port 0) and the load/store requester (port 1). It sits between requesters and `memory_controller`. Each port sees the codebase's enable/busy handshake: hold the enable, watch busy rise, then fall, then drop the enable. The block serialises accesses, forwards one request at a time to the memory, and returns captured read data to the owning port.

---
 rtl/memory_bus_arbiter_pkg.sv | 24 ++
 rtl/arbiter_grant_logic.sv | 44 ++++
 rtl/memory_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// memory_bus_arbiter_pkg
// Shared types and default parameter values for the two-port memory bus arbiter.
// Contents: FSM state enum, port-index type, default parameter constants.
// Optional feature macro used by the importing files: ARBITER_ROUND_ROBIN_EN.
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWaitLow,
        StDone
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_IFETCH = 1'b0;
    localparam port_idx_t PORT_DATA   = 1'b1;

    localparam int unsigned DEF_ADDR_SIZE    = 64;
    localparam int unsigned DEF_DATA_SIZE    = 64;
    localparam int unsigned DEF_BYTE_AMNT    = 8;
    localparam int unsigned DEF_RISE_TIMEOUT = 4;

endpackage

// File: rtl/arbiter_grant_logic.sv
// arbiter_grant_logic
// Combinational grant selection between the two requesters.
// Ports:
//   i_last_grant  port granted most recently (only with ARBITER_ROUND_ROBIN_EN)
//   i_req0/1      raw requests from port 0 / port 1
//   i_mask_vld    a just-served port is currently masked
//   i_mask_port   index of the masked port
//   o_gnt_vld     some unmasked request exists
//   o_gnt_port    index of the port to grant
// Macro: ARBITER_ROUND_ROBIN_EN selects round-robin tie-break, else port 1 wins ties.
module arbiter_grant_logic
    import memory_bus_arbiter_pkg::*;
(
`ifdef ARBITER_ROUND_ROBIN_EN
    input  logic i_last_grant,
`endif
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_mask_vld,
    input  logic i_mask_port,
    output logic o_gnt_vld,
    output logic o_gnt_port
);

    logic w_req0;
    logic w_req1;

    always_comb begin
        w_req0     = i_req0 & ~(i_mask_vld & (i_mask_port == PORT_IFETCH));
        w_req1     = i_req1 & ~(i_mask_vld & (i_mask_port == PORT_DATA));
        o_gnt_vld  = w_req0 | w_req1;
        o_gnt_port = PORT_IFETCH;
        if (w_req0 && w_req1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            o_gnt_port = ~i_last_grant;
`else
            o_gnt_port = PORT_DATA;
`endif
        end else if (w_req1) begin
            o_gnt_port = PORT_DATA;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
// Shares the single-port data memory bus between instruction fetch (port 0) and
// load/store (port 1). Serialises accesses, forwards one latched request at a time
// to the memory controller and returns captured read data to the owning port.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   mN_rd_en/mN_wr_en      request enables of port N (write wins if both set)
//   mN_byte_en/addr/wr_data request payload of port N
//   mN_rd_data, mN_busy    read data and busy handshake back to port N
//   mem_*                  request towards the memory controller
//   mem_rd_data, mem_busy  response from the memory controller
// Macro: ARBITER_ROUND_ROBIN_EN enables round-robin tie-break via last_grant.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE    = DEF_DATA_SIZE,
    parameter int unsigned BYTE_AMNT    = DEF_BYTE_AMNT,
    parameter int unsigned RISE_TIMEOUT = DEF_RISE_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_rd_en,
    input  logic                 m0_wr_en,
    input  logic [BYTE_AMNT-1:0] m0_byte_en,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [DATA_SIZE-1:0] m0_wr_data,
    output logic [DATA_SIZE-1:0] m0_rd_data,
    output logic                 m0_busy,
    input  logic                 m1_rd_en,
    input  logic                 m1_wr_en,
    input  logic [BYTE_AMNT-1:0] m1_byte_en,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [DATA_SIZE-1:0] m1_wr_data,
    output logic [DATA_SIZE-1:0] m1_rd_data,
    output logic                 m1_busy,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BYTE_AMNT-1:0] mem_byte_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wr_data,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    input  logic                 mem_busy
);

    localparam int unsigned CNT_W = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RISE_TIMEOUT - 1);

    arb_state_t           r_state, w_state_d;
    port_idx_t            r_grant;
    logic                 r_rd, r_wr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [BYTE_AMNT-1:0] r_byte_en;
    logic [DATA_SIZE-1:0] r_wr_data;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mask_vld;
    logic                 r_wait0, r_wait1;
    logic [DATA_SIZE-1:0] r_m0_rd_data, r_m1_rd_data;
`ifdef ARBITER_ROUND_ROBIN_EN
    port_idx_t            r_last_grant;
`endif

    logic                 w_req0, w_req1, w_gnt_vld, w_grant_now;
    port_idx_t            w_gnt_port;
    logic                 w_active, w_timeout, w_complete;
    logic                 w_own0, w_own1, w_masked0, w_masked1, w_wait0_d, w_wait1_d;
    logic                 w_sel_rd, w_sel_wr;
    logic [ADDR_SIZE-1:0] w_sel_addr;
    logic [BYTE_AMNT-1:0] w_sel_byte_en;
    logic [DATA_SIZE-1:0] w_sel_wr_data;

    assign w_req0 = m0_rd_en | m0_wr_en;
    assign w_req1 = m1_rd_en | m1_wr_en;

    // The mask reuses r_grant: it still names the just-served port in DONE and the IDLE after.
    arbiter_grant_logic u_grant (
`ifdef ARBITER_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_mask_vld   (r_mask_vld),
        .i_mask_port  (r_grant),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt_port   (w_gnt_port)
    );

    assign w_grant_now = (r_state == StIdle) && w_gnt_vld;
    assign w_active    = (r_state == StAccess) || (r_state == StWaitLow);
    assign w_timeout   = (r_state == StAccess) && !mem_busy && (r_cnt == CNT_MAX);
    assign w_complete  = w_timeout || ((r_state == StWaitLow) && !mem_busy);

    assign w_sel_rd      = (w_gnt_port == PORT_DATA) ? m1_rd_en   : m0_rd_en;
    assign w_sel_wr      = (w_gnt_port == PORT_DATA) ? m1_wr_en   : m0_wr_en;
    assign w_sel_addr    = (w_gnt_port == PORT_DATA) ? m1_addr    : m0_addr;
    assign w_sel_byte_en = (w_gnt_port == PORT_DATA) ? m1_byte_en : m0_byte_en;
    assign w_sel_wr_data = (w_gnt_port == PORT_DATA) ? m1_wr_data : m0_wr_data;

    // A port waits (busy high) while it requests but neither owns the bus nor is masked.
    assign w_own0    = (r_state != StIdle) && (r_grant == PORT_IFETCH);
    assign w_own1    = (r_state != StIdle) && (r_grant == PORT_DATA);
    assign w_masked0 = r_mask_vld && (r_grant == PORT_IFETCH);
    assign w_masked1 = r_mask_vld && (r_grant == PORT_DATA);
    assign w_wait0_d = w_req0 && !w_own0 && !w_masked0 &&
                       !(w_grant_now && (w_gnt_port == PORT_IFETCH));
    assign w_wait1_d = w_req1 && !w_own1 && !w_masked1 &&
                       !(w_grant_now && (w_gnt_port == PORT_DATA));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_gnt_vld) w_state_d = StAccess;
            StAccess: begin
                if (mem_busy)       w_state_d = StWaitLow;
                else if (w_timeout) w_state_d = StDone;
            end
            StWaitLow: if (!mem_busy) w_state_d = StDone;
            StDone:    w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_grant      <= PORT_IFETCH;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_byte_en    <= '0;
            r_wr_data    <= '0;
            r_cnt        <= '0;
            r_mask_vld   <= 1'b0;
            r_wait0      <= 1'b0;
            r_wait1      <= 1'b0;
            r_m0_rd_data <= '0;
            r_m1_rd_data <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            r_last_grant <= PORT_DATA;
`endif
        end else begin
            r_state    <= w_state_d;
            // Covers the DONE cycle and the single IDLE cycle that follows it.
            r_mask_vld <= (r_state == StDone) || (w_state_d == StDone);
            r_wait0    <= w_wait0_d;
            r_wait1    <= w_wait1_d;
            if (w_grant_now) begin
                r_grant   <= w_gnt_port;
                r_wr      <= w_sel_wr;
                r_rd      <= w_sel_rd & ~w_sel_wr;
                r_addr    <= w_sel_addr;
                r_byte_en <= w_sel_byte_en;
                r_wr_data <= w_sel_wr_data;
                r_cnt     <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
                r_last_grant <= w_gnt_port;
`endif
            end else if ((r_state == StAccess) && !mem_busy && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_complete && r_rd) begin
                if (r_grant == PORT_DATA) r_m1_rd_data <= mem_rd_data;
                else                      r_m0_rd_data <= mem_rd_data;
            end
        end
    end

    assign mem_rd_en   = w_active & r_rd;
    assign mem_wr_en   = w_active & r_wr;
    assign mem_addr    = r_addr;
    assign mem_byte_en = r_byte_en;
    assign mem_wr_data = r_wr_data;
    assign m0_rd_data  = r_m0_rd_data;
    assign m1_rd_data  = r_m1_rd_data;
    assign m0_busy     = r_wait0 | (w_active & (r_grant == PORT_IFETCH));
    assign m1_busy     = r_wait1 | (w_active & (r_grant == PORT_DATA));

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter
// Self-checking bench: directed and randomized request scenarios on both ports with
// a behavioural memory slave; expected grant order, access timing and read data
// come from a transaction-level model of the arbiter rules.
module tb_memory_bus_arbiter;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
    logic [7:0]  m0_byte_en, m1_byte_en, mem_byte_en;
    logic [63:0] m0_addr, m0_wr_data, m0_rd_data, m1_addr, m1_wr_data, m1_rd_data;
    logic        m0_busy, m1_busy;
    logic        mem_rd_en, mem_wr_en, mem_busy;
    logic [63:0] mem_addr, mem_wr_data, mem_rd_data;

    always #5 clock = ~clock;

    memory_bus_arbiter #(
        .ADDR_SIZE    (64),
        .DATA_SIZE    (64),
        .BYTE_AMNT    (8),
        .RISE_TIMEOUT (TO)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .m0_rd_en    (m0_rd_en),
        .m0_wr_en    (m0_wr_en),
        .m0_byte_en  (m0_byte_en),
        .m0_addr     (m0_addr),
        .m0_wr_data  (m0_wr_data),
        .m0_rd_data  (m0_rd_data),
        .m0_busy     (m0_busy),
        .m1_rd_en    (m1_rd_en),
        .m1_wr_en    (m1_wr_en),
        .m1_byte_en  (m1_byte_en),
        .m1_addr     (m1_addr),
        .m1_wr_data  (m1_wr_data),
        .m1_rd_data  (m1_rd_data),
        .m1_busy     (m1_busy),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_byte_en (mem_byte_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_busy    (mem_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pending transaction per port plus slave response behaviour.
    logic        t_rd[2], t_wr[2];
    logic [63:0] t_addr[2], t_wdata[2], t_rdata[2];
    logic [7:0]  t_be[2];
    int          t_delay[2], t_len[2], t_hold[2];
    bit          t_noresp[2];

    logic [63:0] exp_rd[2];
    int          mdl_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic port_busy(input int p);
        return (p == 1) ? m1_busy : m0_busy;
    endfunction

    function automatic logic [63:0] port_rd(input int p);
        return (p == 1) ? m1_rd_data : m0_rd_data;
    endfunction

    task automatic drive_port(input int p, input bit on);
        if (p == 0) begin
            m0_rd_en   = on & t_rd[0];
            m0_wr_en   = on & t_wr[0];
            m0_addr    = on ? t_addr[0] : 64'd0;
            m0_wr_data = on ? t_wdata[0] : 64'd0;
            m0_byte_en = on ? t_be[0] : 8'd0;
        end else begin
            m1_rd_en   = on & t_rd[1];
            m1_wr_en   = on & t_wr[1];
            m1_addr    = on ? t_addr[1] : 64'd0;
            m1_wr_data = on ? t_wdata[1] : 64'd0;
            m1_byte_en = on ? t_be[1] : 8'd0;
        end
    endtask

    task automatic set_txn(input int p, input bit rd, input bit wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] be,
                           input logic [63:0] rdata, input int delay, input int len,
                           input bit noresp, input int hold);
        t_rd[p] = rd;       t_wr[p] = wr;       t_addr[p] = addr;
        t_wdata[p] = wdata; t_be[p] = be;       t_rdata[p] = rdata;
        t_delay[p] = delay; t_len[p] = len;     t_noresp[p] = noresp;
        t_hold[p] = hold;
    endtask

    task automatic rand_txn(input int p);
        int pat;
        pat = $urandom_range(0, 2);
        set_txn(p, pat != 1, pat != 0, {$urandom, $urandom}, {$urandom, $urandom},
                8'($urandom), {$urandom, $urandom}, $urandom_range(0, TO - 1),
                $urandom_range(1, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 2));
    endtask

    // Run one scenario: the selected ports raise their requests in the same cycle.
    task automatic run(input bit use0, input bit use1);
        int order[$];
        int w, served, n_acc, cur, a, k, exp_done, prev_done;
        int drop_at[2];
        bit en_prev, en_now;
        order = {};
        if (use0 && use1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            w = 1 - mdl_last;
`else
            w = 1;
`endif
            order.push_back(w);
            order.push_back(1 - w);
        end else begin
            order.push_back(use0 ? 0 : 1);
        end
        served = 0; n_acc = 0; cur = -1; a = -1; exp_done = -1; prev_done = 0;
        drop_at = '{-1, -1};
        en_prev = 1'b0;
        if (use0) drive_port(0, 1'b1);
        if (use1) drive_port(1, 1'b1);
        for (int c = 1; c <= 120; c++) begin
            @(posedge clock); #1;
            if (c == 1 && use0 && use1) begin
                check("tie_busy0", m0_busy, 1'b1);
                check("tie_busy1", m1_busy, 1'b1);
            end
            en_now = mem_rd_en | mem_wr_en;
            if (en_now && !en_prev) begin
                n_acc++;
                if (cur < 0 && served < order.size()) begin
                    cur = order[served];
                    a   = c;
                    check("acc_addr", mem_addr, t_addr[cur]);
                    check("acc_wdata", mem_wr_data, t_wdata[cur]);
                    check("acc_be", mem_byte_en, t_be[cur]);
                    check("acc_rd_en", mem_rd_en, t_rd[cur] & ~t_wr[cur]);
                    check("acc_wr_en", mem_wr_en, t_wr[cur]);
                    if (served == 0) check("grant_latency", c, 1);
                    else             check("turnaround", c - prev_done, 2);
                    exp_done = t_noresp[cur] ? c + TO : c + t_delay[cur] + t_len[cur] + 1;
                end
            end
            en_prev = en_now;
            if (cur >= 0 && c == exp_done - 1) check("pre_done_busy", port_busy(cur), 1'b1);
            if (cur >= 0 && c == exp_done) begin
                if (t_rd[cur] && !t_wr[cur]) exp_rd[cur] = t_rdata[cur];
                check("done_mem_en", en_now, 1'b0);
                check("done_busy", port_busy(cur), 1'b0);
                check("rd_data", port_rd(cur), exp_rd[cur]);
                check("other_rd_data", port_rd(1 - cur), exp_rd[1 - cur]);
                if (served + 1 < order.size()) check("other_wait", port_busy(1 - cur), 1'b1);
                drop_at[cur] = c + t_hold[cur];
                prev_done = c;
                served++;
                cur = -1;
            end
            for (int p = 0; p < 2; p++) if (c == drop_at[p]) drive_port(p, 1'b0);
            mem_busy    = 1'b0;
            mem_rd_data = {$urandom, $urandom};
            if (cur >= 0) begin
                k = c - a;
                if (t_noresp[cur]) begin
                    mem_rd_data = t_rdata[cur];
                end else begin
                    mem_busy = (k >= t_delay[cur]) && (k < t_delay[cur] + t_len[cur]);
                    if (k == t_delay[cur] + t_len[cur]) mem_rd_data = t_rdata[cur];
                end
            end
            if (served == order.size() && c >= prev_done + 5) break;
        end
        check("access_count", n_acc, order.size());
        drive_port(0, 1'b0);
        drive_port(1, 1'b0);
        mem_busy = 1'b0;
        mdl_last = order[order.size() - 1];
    endtask

    task automatic reset_mid_access();
        set_txn(0, 1'b1, 1'b0, {$urandom, $urandom} | 64'h1, 64'd0, 8'hFF, 64'd0, 0, 10,
                1'b0, 0);
        drive_port(0, 1'b1);
        @(posedge clock); #1;
        check("rst_pre_en", mem_rd_en, 1'b1);
        mem_busy = 1'b1;
        @(posedge clock); #1;
        check("rst_pre_busy", m0_busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_m0_busy", m0_busy, 1'b0);
        check("rst_m0_rd_data", m0_rd_data, 64'd0);
        check("rst_m1_rd_data", m1_rd_data, 64'd0);
        drive_port(0, 1'b0);
        mem_busy = 1'b0;
        @(posedge clock); #1;
        reset    = 1'b0;
        exp_rd   = '{64'd0, 64'd0};
        mdl_last = 1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            set_txn(p, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 64'd0, 0, 1, 1'b0, 0);
            drive_port(p, 1'b0);
        end
        mem_busy    = 1'b0;
        mem_rd_data = 64'd0;
        exp_rd      = '{64'd0, 64'd0};
        mdl_last    = 1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_m0_busy", m0_busy, 1'b0);
        check("reset_m1_busy", m1_busy, 1'b0);
        check("reset_mem_en", {mem_rd_en, mem_wr_en}, 2'b00);
        check("reset_mem_addr", mem_addr, 64'd0);
        check("reset_mem_wdata", mem_wr_data, 64'd0);
        check("reset_mem_be", mem_byte_en, 8'd0);
        check("reset_rd_data", {m0_rd_data ^ m1_rd_data}, 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Port 0 read, slave busy for two cycles.
        set_txn(0, 1'b1, 1'b0, 64'h0, 64'h0, 8'hFF, 64'h13, 0, 2, 1'b0, 0);
        run(1'b1, 1'b0);
        // Repeated ties.
        for (int i = 0; i < 3; i++) begin
            rand_txn(0);
            rand_txn(1);
            run(1'b1, 1'b1);
        end
        // Port 1 write leaves m1_rd_data untouched.
        set_txn(1, 1'b0, 1'b1, 64'h40, 64'hDEADBEEF, 8'h0F, 64'h5555, 1, 2, 1'b0, 0);
        run(1'b0, 1'b1);
        // Slave never raises busy.
        set_txn(0, 1'b1, 1'b0, 64'h80, 64'h0, 8'hFF, 64'hCAFE_F00D, 0, 1, 1'b1, 0);
        run(1'b1, 1'b0);
        // Both ports hold their enables into the mask window.
        set_txn(0, 1'b1, 1'b0, 64'h100, 64'h0, 8'hFF, 64'h1111, 1, 1, 1'b0, 2);
        set_txn(1, 1'b1, 1'b0, 64'h200, 64'h0, 8'hFF, 64'h2222, 0, 3, 1'b0, 2);
        run(1'b1, 1'b1);
        // Reset in WAIT_LOW, then normal service.
        reset_mid_access();
        rand_txn(0);
        run(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            rand_txn(0);
            rand_txn(1);
            run(kind != 1, kind != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
